// File: rtl/ring_pkg.sv
// Shared types, limits and width helpers for the ring link repeater.
package ring_pkg;

    localparam int MAX_LINK_STAGES   = 8;
    localparam int MAX_CREDIT_STAGES = 8;
    localparam int DEF_FLIT_WIDTH    = 256;
    localparam int DEF_DEST_WIDTH    = 4;

    typedef struct packed {
        logic                      is_tail;
        logic [DEF_DEST_WIDTH-1:0] dest;
        logic [DEF_FLIT_WIDTH-1:0] data;
    } flit_t;

    function automatic int flit_bits(int fw, int dw);
        return fw + dw + 1;
    endfunction

    function automatic int credit_cnt_width(int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/ring_link_channel.sv
// One ring channel: forward pipe, RX FIFO, downstream credit counter,
// returned-credit pipe and sticky error flags.
module ring_link_channel
    import ring_pkg::*;
#(
    parameter int FLIT_WIDTH    = 256,
    parameter int DEST_WIDTH    = 4,
    parameter int LINK_STAGES   = 2,
    parameter int CREDIT_STAGES = 2,
    parameter int RX_DEPTH      = 8,
    parameter int DN_CREDITS    = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [FLIT_WIDTH-1:0] up_data,
    input  logic [DEST_WIDTH-1:0] up_dest,
    input  logic                  up_is_tail,
    input  logic                  up_send,
    output logic                  up_credit,
    output logic [FLIT_WIDTH-1:0] dn_data,
    output logic [DEST_WIDTH-1:0] dn_dest,
    output logic                  dn_is_tail,
    output logic                  dn_send,
    input  logic                  dn_credit,
    output logic                  err_overflow,
    output logic                  err_credit
);

    localparam int FB  = flit_bits(FLIT_WIDTH, DEST_WIDTH);
    localparam int CW  = credit_cnt_width(DN_CREDITS);
    localparam int OW  = credit_cnt_width(RX_DEPTH);
    localparam int PW  = $clog2(RX_DEPTH);
    localparam int CRW = CREDIT_STAGES + 1;

    logic [FB-1:0]  up_f;
    logic [FB-1:0]  wr_f;
    logic [FB-1:0]  head;
    logic [FB-1:0]  mem [RX_DEPTH];
    logic           wr_v;
    logic [OW-1:0]  count;
    logic [PW-1:0]  rd_ptr;
    logic [PW-1:0]  wr_ptr;
    logic [CW-1:0]  credits;
    logic [CRW-1:0] cr_q;
    logic           full;
    logic           pop;
    logic           bypass;
    logic           push;
    logic           pull;

    assign up_f = {up_is_tail, up_dest, up_data};

    if (LINK_STAGES == 0) begin : g_direct
        assign wr_v = up_send;
        assign wr_f = up_f;
    end else begin : g_pipe
        logic [LINK_STAGES-1:0] fv;
        logic [FB-1:0]          fd [LINK_STAGES];

        always_ff @(posedge clk) begin
            if (!rst_n) fv <= '0;
            else        fv <= (fv << 1) | LINK_STAGES'(up_send);
        end

        always_ff @(posedge clk) begin
            fd[0] <= up_f;
            for (int i = 1; i < LINK_STAGES; i++) fd[i] <= fd[i-1];
        end

        assign wr_v = fv[LINK_STAGES-1];
        assign wr_f = fd[LINK_STAGES-1];
    end

    function automatic logic [PW-1:0] nxt(logic [PW-1:0] p);
        return (p == PW'(RX_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // An empty FIFO hands the last forward register straight to the pop.
    assign head   = (count == '0) ? wr_f : mem[rd_ptr];
    assign full   = count == OW'(RX_DEPTH);
    assign pop    = (count != '0 || wr_v) && credits != '0;
    assign bypass = pop && count == '0;
    assign push   = wr_v && !bypass && (!full || pop);
    assign pull   = pop && !bypass;

    assign up_credit = cr_q[CREDIT_STAGES];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count        <= '0;
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            credits      <= CW'(DN_CREDITS);
            cr_q         <= '0;
            dn_send      <= 1'b0;
            err_overflow <= 1'b0;
            err_credit   <= 1'b0;
        end else begin
            dn_send <= pop;
            cr_q    <= (cr_q << 1) | CRW'(pop);
            count   <= count + OW'(push) - OW'(pull);
            if (push) wr_ptr <= nxt(wr_ptr);
            if (pull) rd_ptr <= nxt(rd_ptr);
            if (wr_v && full && !pop) err_overflow <= 1'b1;
            if (pop && !dn_credit) begin
                credits <= credits - CW'(1);
            end else if (dn_credit && !pop) begin
                if (credits == CW'(DN_CREDITS)) err_credit <= 1'b1;
                else                            credits <= credits + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_f;
        if (pop)  {dn_is_tail, dn_dest, dn_data} <= head;
    end

endmodule

// File: rtl/ring_link_pipe.sv
// Credit-domain repeater between two ring routers, one independent
// channel instance per parallel ring.
module ring_link_pipe
    import ring_pkg::*;
#(
    parameter int NUM_CHANNELS  = 2,
    parameter int FLIT_WIDTH    = 256,
    parameter int DEST_WIDTH    = 4,
    parameter int LINK_STAGES   = 2,
    parameter int CREDIT_STAGES = 2,
    parameter int RX_DEPTH      = 8,
    parameter int DN_CREDITS    = 2
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic [NUM_CHANNELS-1:0][FLIT_WIDTH-1:0] up_data,
    input  logic [NUM_CHANNELS-1:0][DEST_WIDTH-1:0] up_dest,
    input  logic [NUM_CHANNELS-1:0]                 up_is_tail,
    input  logic [NUM_CHANNELS-1:0]                 up_send,
    output logic [NUM_CHANNELS-1:0]                 up_credit,
    output logic [NUM_CHANNELS-1:0][FLIT_WIDTH-1:0] dn_data,
    output logic [NUM_CHANNELS-1:0][DEST_WIDTH-1:0] dn_dest,
    output logic [NUM_CHANNELS-1:0]                 dn_is_tail,
    output logic [NUM_CHANNELS-1:0]                 dn_send,
    input  logic [NUM_CHANNELS-1:0]                 dn_credit,
    output logic [NUM_CHANNELS-1:0]                 err_overflow,
    output logic [NUM_CHANNELS-1:0]                 err_credit
);

    if (LINK_STAGES < 0 || LINK_STAGES > MAX_LINK_STAGES) begin : g_bad_link
        $fatal(1, "ring_link_pipe: LINK_STAGES out of range");
    end
    if (CREDIT_STAGES < 0 || CREDIT_STAGES > MAX_CREDIT_STAGES) begin : g_bad_cr
        $fatal(1, "ring_link_pipe: CREDIT_STAGES out of range");
    end
    if (RX_DEPTH < 2) begin : g_bad_depth
        $fatal(1, "ring_link_pipe: RX_DEPTH must be at least 2");
    end
    if (DN_CREDITS < 1 || NUM_CHANNELS < 1 || FLIT_WIDTH < 1 || DEST_WIDTH < 1) begin : g_bad_misc
        $fatal(1, "ring_link_pipe: illegal width or count parameter");
    end

    for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch
        ring_link_channel #(
            .FLIT_WIDTH    (FLIT_WIDTH),
            .DEST_WIDTH    (DEST_WIDTH),
            .LINK_STAGES   (LINK_STAGES),
            .CREDIT_STAGES (CREDIT_STAGES),
            .RX_DEPTH      (RX_DEPTH),
            .DN_CREDITS    (DN_CREDITS)
        ) u_ch (
            .clk          (clk),
            .rst_n        (rst_n),
            .up_data      (up_data[c]),
            .up_dest      (up_dest[c]),
            .up_is_tail   (up_is_tail[c]),
            .up_send      (up_send[c]),
            .up_credit    (up_credit[c]),
            .dn_data      (dn_data[c]),
            .dn_dest      (dn_dest[c]),
            .dn_is_tail   (dn_is_tail[c]),
            .dn_send      (dn_send[c]),
            .dn_credit    (dn_credit[c]),
            .err_overflow (err_overflow[c]),
            .err_credit   (err_credit[c])
        );
    end

endmodule

// File: tb/tb_ring_link_pipe.sv
// Scoreboard bench for ring_link_pipe: latency, streaming, backpressure,
// credit errors, mid-stream reset and random multi-channel traffic.
module tb_ring_link_pipe;

    localparam int NC = 4;
    localparam int FW = 64;
    localparam int DW = 4;
    localparam int LS = 2;
    localparam int CS = 2;
    localparam int RX = 8;
    localparam int DN = 2;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic [NC-1:0][FW-1:0]  up_data;
    logic [NC-1:0][DW-1:0]  up_dest;
    logic [NC-1:0]          up_is_tail;
    logic [NC-1:0]          up_send;
    logic [NC-1:0]          up_credit;
    logic [NC-1:0][FW-1:0]  dn_data;
    logic [NC-1:0][DW-1:0]  dn_dest;
    logic [NC-1:0]          dn_is_tail;
    logic [NC-1:0]          dn_send;
    logic [NC-1:0]          dn_credit;
    logic [NC-1:0]          err_overflow;
    logic [NC-1:0]          err_credit;

    ring_link_pipe #(
        .NUM_CHANNELS  (NC),
        .FLIT_WIDTH    (FW),
        .DEST_WIDTH    (DW),
        .LINK_STAGES   (LS),
        .CREDIT_STAGES (CS),
        .RX_DEPTH      (RX),
        .DN_CREDITS    (DN)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .up_data      (up_data),
        .up_dest      (up_dest),
        .up_is_tail   (up_is_tail),
        .up_send      (up_send),
        .up_credit    (up_credit),
        .dn_data      (dn_data),
        .dn_dest      (dn_dest),
        .dn_is_tail   (dn_is_tail),
        .dn_send      (dn_send),
        .dn_credit    (dn_credit),
        .err_overflow (err_overflow),
        .err_credit   (err_credit)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int run    = 0;
    int max_run = 0;
    bit rnd_cr = 1'b0;

    logic [FW+DW:0] exp_q [NC][$];
    int held [NC];
    int avail [NC];
    int owed [NC];
    int dn_n [NC];
    int cr_n [NC];
    int last_dn [NC];
    int last_cr [NC];
    bit auto_cr [NC];
    bit extra [NC];

    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [127:0] got,
                       input logic [127:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    // Downstream router model and output scoreboard.
    always @(negedge clk) begin
        logic [FW+DW:0] e;
        if (rst_n) begin
            for (int c = 0; c < NC; c++) begin
                if (up_credit[c]) begin
                    held[c]++;
                    cr_n[c]++;
                    last_cr[c] = cyc;
                    chk("up_credit_bound", held[c] <= RX, 1'b1);
                end
                if (dn_send[c]) begin
                    dn_n[c]++;
                    last_dn[c] = cyc;
                    chk("dn_credit_respected", avail[c] > 0, 1'b1);
                    if (avail[c] > 0) avail[c]--;
                    if (exp_q[c].size() == 0) begin
                        chk("dn_unexpected", dn_send[c], 1'b0);
                    end else begin
                        e = exp_q[c].pop_front();
                        chk($sformatf("flit_ch%0d", c),
                            {dn_is_tail[c], dn_dest[c], dn_data[c]}, e);
                    end
                    if (auto_cr[c]) owed[c]++;
                end
                dn_credit[c] = extra[c];
                extra[c] = 1'b0;
                if (owed[c] > 0 && (!rnd_cr || $urandom_range(1) == 1)) begin
                    dn_credit[c] = 1'b1;
                    owed[c]--;
                end
                if (dn_credit[c] && avail[c] < DN) avail[c]++;
            end
            if (dn_send[0]) run++;
            else            run = 0;
            if (run > max_run) max_run = run;
        end else begin
            dn_credit = '0;
        end
    end

    task automatic reset_models();
        for (int c = 0; c < NC; c++) begin
            exp_q[c].delete();
            held[c]    = RX;
            avail[c]   = DN;
            owed[c]    = 0;
            extra[c]   = 1'b0;
            auto_cr[c] = 1'b1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        up_send = '0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) tick();
    endtask

    task automatic put(input int c, input bit legal);
        logic [FW+DW:0] f;
        f[FW-1:0]     = {$urandom, $urandom};
        f[FW+DW-1:FW] = DW'($urandom);
        f[FW+DW]      = 1'($urandom_range(1));
        {up_is_tail[c], up_dest[c], up_data[c]} = f;
        up_send[c] = 1'b1;
        if (legal) begin
            exp_q[c].push_back(f);
            held[c]--;
        end
    endtask

    initial begin
        int ts;
        int base;
        int sent;
        int stalls;
        int n;
        bit busy;

        up_send    = '0;
        up_data    = '0;
        up_dest    = '0;
        up_is_tail = '0;
        rst_n      = 1'b0;
        for (int c = 0; c < NC; c++) begin
            dn_n[c]    = 0;
            cr_n[c]    = 0;
            last_dn[c] = -100;
            last_cr[c] = -100;
        end
        reset_models();

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_dn_send", dn_send, '0);
        chk("rst_up_credit", up_credit, '0);
        chk("rst_err_overflow", err_overflow, '0);
        chk("rst_err_credit", err_credit, '0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        wait_cycles(3);

        // Single flit, minimum latency
        base = cr_n[0];
        ts = cyc;
        put(0, 1'b1);
        tick();
        wait_cycles(10);
        chk("single_dn_latency", last_dn[0] - ts, LS + 1);
        chk("single_credit_latency", last_cr[0] - ts, LS + CS + 1);
        chk("single_credit_count", cr_n[0] - base, 1);

        // Streaming at full rate
        max_run = 0;
        base = dn_n[0];
        sent = 0;
        stalls = 0;
        while (sent < 1000 && stalls < 100) begin
            if (held[0] > 0) begin
                put(0, 1'b1);
                sent++;
            end else begin
                stalls++;
            end
            tick();
        end
        wait_cycles(20);
        chk("stream_stalls", stalls, 0);
        chk("stream_count", dn_n[0] - base, 1000);
        chk("stream_run", max_run, 1000);
        chk("stream_credits", held[0], RX);
        chk("stream_errors", {err_overflow, err_credit}, '0);

        // Backpressure and overflow
        auto_cr[0] = 1'b0;
        base = dn_n[0];
        sent = 0;
        n = 0;
        while (sent < 10 && n < 100) begin
            if (held[0] > 0) begin
                put(0, 1'b1);
                sent++;
            end
            tick();
            n++;
        end
        wait_cycles(10);
        chk("bp_passed", dn_n[0] - base, 2);
        chk("bp_no_overflow_yet", err_overflow[0], 1'b0);
        put(0, 1'b0);
        tick();
        wait_cycles(LS + 3);
        chk("bp_overflow", err_overflow[0], 1'b1);
        chk("bp_overflow_isolated", err_overflow[1], 1'b0);
        auto_cr[0] = 1'b1;
        owed[0] += 2;
        n = 0;
        while (exp_q[0].size() > 0 && n < 200) begin
            tick();
            n++;
        end
        wait_cycles(10);
        chk("bp_drained", exp_q[0].size(), 0);
        chk("bp_total", dn_n[0] - base, 10);
        chk("bp_credits", held[0], RX);

        // Extra credit at a full counter saturates and flags
        extra[1] = 1'b1;
        wait_cycles(3);
        chk("crerr_set", err_credit[1], 1'b1);
        chk("crerr_isolated", err_credit[0], 1'b0);
        auto_cr[1] = 1'b0;
        base = dn_n[1];
        repeat (3) begin
            put(1, 1'b1);
            tick();
        end
        wait_cycles(10);
        chk("crerr_counter_held", dn_n[1] - base, 2);
        auto_cr[1] = 1'b1;
        owed[1] += 2;
        wait_cycles(10);
        chk("crerr_release", dn_n[1] - base, 3);

        // Mid-stream reset with flits buffered
        auto_cr[0] = 1'b0;
        base = dn_n[0];
        repeat (7) begin
            put(0, 1'b1);
            tick();
        end
        wait_cycles(5);
        chk("mrst_pre_passed", dn_n[0] - base, 2);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        reset_models();
        @(negedge clk);
        chk("mrst_dn_send", dn_send, '0);
        chk("mrst_up_credit", up_credit, '0);
        chk("mrst_err_overflow", err_overflow, '0);
        chk("mrst_err_credit", err_credit, '0);
        @(posedge clk);
        #1;
        base = dn_n[0];
        ts = cyc;
        put(0, 1'b1);
        tick();
        wait_cycles(10);
        chk("mrst_latency", last_dn[0] - ts, LS + 1);
        chk("mrst_count", dn_n[0] - base, 1);
        chk("mrst_credits", held[0], RX);

        // Random independent traffic on all channels
        rnd_cr = 1'b1;
        for (int k = 0; k < 400; k++) begin
            for (int c = 0; c < NC; c++) begin
                if (held[c] > 0 && $urandom_range(3) != 0) put(c, 1'b1);
            end
            tick();
        end
        n = 0;
        busy = 1'b1;
        while (busy && n < 500) begin
            busy = 1'b0;
            for (int c = 0; c < NC; c++) begin
                if (exp_q[c].size() > 0 || owed[c] > 0) busy = 1'b1;
            end
            tick();
            n++;
        end
        wait_cycles(15);
        for (int c = 0; c < NC; c++) begin
            chk($sformatf("rand_drained_ch%0d", c), exp_q[c].size(), 0);
            chk($sformatf("rand_credits_ch%0d", c), held[c], RX);
            chk($sformatf("rand_err_ch%0d", c),
                {err_overflow[c], err_credit[c]}, 2'b00);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
